// File: rtl/hft_stream_mux.sv
// hft_stream_mux: NUM_CH-channel packet mux, per-channel FIFO, round-robin, whole packets only (STREAM_MUX_STATS_EN adds counters).
// Latency: single-beat packet written at cycle N is presented at N+2; one idle cycle between packets.
// Backpressure: s_tready drops on full or disabled channel; m_tready low holds the presented beat.
module hft_stream_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_CH-1:0]            s_tvalid,
  input  logic [NUM_CH-1:0]            s_tlast,
  output logic [NUM_CH-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]        m_tdata,
  output logic                         m_tvalid,
  output logic                         m_tlast,
  output logic [$clog2(NUM_CH)-1:0]    m_tdest,
  input  logic                         m_tready,
  input  logic [NUM_CH-1:0]            ch_enable,
  output logic [NUM_CH-1:0]            fifo_full,
  output logic [CNT_WIDTH-1:0]         pkt_count,
  output logic [CNT_WIDTH-1:0]         drop_count
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam int PW   = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t                           state, state_nxt;
  logic [CH_W-1:0]                  sel, sel_nxt, rr_ptr, rr_nxt, pick;
  logic                             pick_vld, pop, cur_vld, cur_last;
  logic [NUM_CH-1:0]                wr_en, rd_en, empty, eligible;
  logic [NUM_CH-1:0][DATA_WIDTH:0]  head;

  assign s_tready = ch_enable & ~fifo_full & {NUM_CH{~rst}};
  assign wr_en    = s_tvalid & s_tready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic          wr_last, rd_last;
    logic [PW-1:0] pkt_cnt;

    hft_stream_mux_fifo #(.WIDTH(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_vld (wr_en[i]),
      .wr_dat ({s_tlast[i], s_tdata[i*DATA_WIDTH +: DATA_WIDTH]}),
      .rd_rdy (rd_en[i]),
      .rd_dat (head[i]),
      .full   (fifo_full[i]),
      .empty  (empty[i])
    );

    // Complete packets buffered; a full FIFO also qualifies so oversize packets cut through.
    assign wr_last = wr_en[i] & s_tlast[i];
    assign rd_last = rd_en[i] & head[i][DATA_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                      pkt_cnt <= '0;
      else if (wr_last & ~rd_last)  pkt_cnt <= pkt_cnt + 1'b1;
      else if (rd_last & ~wr_last)  pkt_cnt <= pkt_cnt - 1'b1;
    end

    assign eligible[i] = (pkt_cnt != '0) | fifo_full[i];
    assign rd_en[i]    = pop & (sel == CH_W'(i));
  end

  assign cur_vld  = (state == XFER) & ~empty[sel];
  assign cur_last = head[sel][DATA_WIDTH];
  assign pop      = cur_vld & m_tready;
  assign m_tvalid = cur_vld;
  assign m_tdata  = cur_vld ? head[sel][DATA_WIDTH-1:0] : '0;
  assign m_tlast  = cur_vld & cur_last;
  assign m_tdest  = sel;

  always_comb begin
    int idx;
    pick_vld = 1'b0;
    pick     = rr_ptr;
    idx      = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!pick_vld && eligible[idx[CH_W-1:0]]) begin
        pick_vld = 1'b1;
        pick     = idx[CH_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sel    <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      sel    <= sel_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    rr_nxt    = rr_ptr;
    case (state)
      IDLE: if (pick_vld) begin
        sel_nxt   = pick;
        state_nxt = XFER;
      end
      XFER: if (pop && cur_last) begin
        rr_nxt    = (sel == CH_W'(NUM_CH - 1)) ? '0 : sel + 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef STREAM_MUX_STATS_EN
  logic [CNT_WIDTH-1:0] pkt_q, drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_q  <= '0;
      drop_q <= '0;
    end else begin
      if (pop && cur_last && pkt_q != '1)          pkt_q  <= pkt_q + 1'b1;
      if (|(s_tvalid & ~s_tready) && drop_q != '1) drop_q <= drop_q + 1'b1;
    end
  end

  assign pkt_count  = pkt_q;
  assign drop_count = drop_q;
`else
  assign pkt_count  = '0;
  assign drop_count = '0;
`endif
endmodule

// hft_stream_mux_fifo: generic first-word-fall-through FIFO, DEPTH a power of two.
// Latency: a written word appears on rd_dat the cycle after the write.
// Backpressure: writes ignored while full, reads ignored while empty.
module hft_stream_mux_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_wr, do_rd;

  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign do_wr  = wr_vld & ~full;
  assign do_rd  = rd_rdy & ~empty;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      count <= count + 1'b1;
      else if (do_rd && !do_wr) count <= count - 1'b1;
    end
  end
endmodule

// File: tb/tb_hft_stream_mux.sv
// Randomized bench for hft_stream_mux: per-channel scoreboard queues, FIFO occupancy model, directed corner cases.
module tb_hft_stream_mux;
  localparam int DW = 32, NCH = 4, DEPTH = 16, CW = 16, TW = $clog2(NCH);

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NCH*DW-1:0]   s_tdata;
  logic [NCH-1:0]      s_tvalid, s_tlast, s_tready, ch_enable, fifo_full;
  logic [DW-1:0]       m_tdata;
  logic                m_tvalid, m_tlast, m_tready;
  logic [TW-1:0]       m_tdest;
  logic [CW-1:0]       pkt_count, drop_count;

  hft_stream_mux #(.DATA_WIDTH(DW), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tdest(m_tdest), .m_tready(m_tready), .ch_enable(ch_enable), .fifo_full(fifo_full),
    .pkt_count(pkt_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  logic [DW:0]       src_q [NCH][$];
  logic [DW:0]       exp_q [NCH][$];
  int                occ [NCH];
  int                out_order [$];
  logic [NCH-1:0]    acc = '0;
  int                n_chk = 0, n_fail = 0;
  int                n_pkts = 0, n_beats = 0, cyc = 0, hs_first = -1, hs_last = -1;
  int                tready_mode = 0;
  bit                drv_en = 0, gap_en = 0, saw_full1 = 0;
  bit                in_pkt = 0, prev_stall = 0, prev_last_hs = 0;
  int                pkt_dest = 0;
  logic [DW+TW+1:0]  prev_out = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit idle();
    bit r;
    r = (s_tvalid == '0) && !m_tvalid;
    for (int i = 0; i < NCH; i++)
      if (src_q[i].size() != 0 || exp_q[i].size() != 0) r = 0;
    return r;
  endfunction

  task automatic push_pkt(input int ch, input int len, input logic [DW-1:0] base, input bit rnd);
    for (int b = 0; b < len; b++)
      src_q[ch].push_back({(b == len - 1), (rnd ? DW'($urandom) : base + DW'(b))});
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (n < budget && !idle()) begin
      @(posedge clk); #2;
      n++;
    end
    check(tag, n < budget, 1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    drv_en = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    s_tvalid = '0;
    for (int i = 0; i < NCH; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
      occ[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drv_en = 1;
  endtask

  // Source/sink driver: holds a beat until accepted, optional random gaps and m_tready patterns.
  initial forever begin
    @(posedge clk); #1;
    if (drv_en) begin
      case (tready_mode)
        0: m_tready = 1'b1;
        1: m_tready = ($urandom_range(1) == 1);
        2: m_tready = ~m_tready;
        default: m_tready = 1'b0;
      endcase
      for (int i = 0; i < NCH; i++) begin
        if (acc[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        if (!(s_tvalid[i] && !acc[i]))
          s_tvalid[i] = (src_q[i].size() != 0) && (!gap_en || $urandom_range(3) != 0);
        if (s_tvalid[i]) {s_tlast[i], s_tdata[i*DW +: DW]} = src_q[i][0];
      end
    end
  end

  // Monitor: values at the falling edge are those the next rising edge samples.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      acc = '0; prev_stall = 0; prev_last_hs = 0; in_pkt = 0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        check("fifo_full", fifo_full[i], occ[i] == DEPTH);
        check("s_tready", s_tready[i], ch_enable[i] && occ[i] != DEPTH);
        if (i == 1 && fifo_full[i]) saw_full1 = 1;
      end
      if (prev_stall) check("axi_hold", {m_tvalid, m_tlast, m_tdest, m_tdata}, prev_out);
      if (prev_last_hs) check("bubble", m_tvalid, 0);
      acc = s_tvalid & s_tready;
      for (int i = 0; i < NCH; i++)
        if (acc[i]) begin
          exp_q[i].push_back({s_tlast[i], s_tdata[i*DW +: DW]});
          occ[i]++;
        end
      if (m_tvalid && m_tready) begin
        int d;
        d = int'(m_tdest);
        if (in_pkt) check("no_interleave", m_tdest, pkt_dest);
        else begin
          out_order.push_back(d);
          pkt_dest = d;
        end
        if (exp_q[d].size() == 0) check("unexpected_beat", {m_tlast, m_tdata}, 0);
        else check("beat", {m_tlast, m_tdata}, exp_q[d].pop_front());
        occ[d]--;
        in_pkt = !m_tlast;
        if (m_tlast) n_pkts++;
        n_beats++;
        if (hs_first < 0) hs_first = cyc;
        hs_last = cyc;
      end
      prev_stall   = m_tvalid && !m_tready;
      prev_out     = {m_tvalid, m_tlast, m_tdest, m_tdata};
      prev_last_hs = m_tvalid && m_tready && m_tlast;
    end
  end

  initial begin
    int p0, b0, n;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b1; ch_enable = '1;
    for (int i = 0; i < NCH; i++) occ[i] = 0;

    // Reset with all inputs valid
    repeat (2) @(posedge clk);
    #1 s_tvalid = '1;
    @(posedge clk); #1;
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tdest", m_tdest, 0);
    check("rst_fifo_full", fifo_full, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_drop_count", drop_count, 0);
    ch_enable = 4'b1011;
    s_tvalid = '0;
    rst = 1'b0;
    #1 check("rel_s_tready", s_tready, 4'b1011);
    ch_enable = '1;
    drv_en = 1;

    // Single-beat latency
    @(posedge clk); #2;
    push_pkt(0, 1, 32'hA5A5_0001, 0);
    @(posedge clk); #2;
    check("lat_s_tvalid_n", s_tvalid[0], 1);
    @(posedge clk); #2;
    check("lat_m_tvalid_n1", m_tvalid, 0);
    @(posedge clk); #2;
    check("lat_m_tvalid_n2", m_tvalid, 1);
    check("lat_m_tdest", m_tdest, 0);
    check("lat_m_tlast", m_tlast, 1);
    check("lat_m_tdata", m_tdata, 32'hA5A5_0001);
    wait_drain("lat_drain", 50);

    // Round-robin order with all four channels loaded
    do_reset();
    tready_mode = 3;
    for (int c = 0; c < NCH; c++) push_pkt(c, 3, 32'h100 * (c + 1), 0);
    repeat (12) @(posedge clk);
    out_order.delete();
    hs_first = -1;
    tready_mode = 0;
    wait_drain("rr_drain", 200);
    check("rr_count", out_order.size(), NCH);
    for (int k = 0; k < NCH && k < out_order.size(); k++) check("rr_order", out_order[k], k);
    check("rr_span", hs_last - hs_first + 1, NCH * 3 + NCH - 1);

    // Oversize packet cuts through once full
    do_reset();
    saw_full1 = 0;
    out_order.delete();
    p0 = n_pkts; b0 = n_beats;
    push_pkt(1, 20, 32'h0, 1);
    wait_drain("ct_drain", 300);
    check("ct_full_seen", saw_full1, 1);
    check("ct_beats", n_beats - b0, 20);
    check("ct_pkts", n_pkts - p0, 1);
    if (out_order.size() != 0) check("ct_dest", out_order[0], 1);

    // Toggling m_tready mid-packet
    tready_mode = 2;
    b0 = n_beats;
    push_pkt(0, 10, 32'h0, 1);
    push_pkt(3, 6, 32'h0, 1);
    wait_drain("stall_drain", 300);
    check("stall_beats", n_beats - b0, 16);

    // Random traffic
    tready_mode = 1;
    gap_en = 1;
    p0 = n_pkts;
    for (int k = 0; k < 40; k++)
      push_pkt($urandom_range(NCH - 1), ($urandom_range(4) == 0) ? $urandom_range(24, 17) : $urandom_range(12, 1), 32'h0, 1);
    wait_drain("rand_drain", 20000);
    check("rand_pkts", n_pkts - p0, 40);
    gap_en = 0;

    // Reset mid-packet discards buffered data
    tready_mode = 3;
    push_pkt(3, 10, 32'h0, 1);
    push_pkt(0, 2, 32'h0, 1);
    repeat (8) @(posedge clk);
    do_reset();
    tready_mode = 0;
    b0 = n_beats;
    repeat (20) @(posedge clk);
    #2;
    check("rst_flush_beats", n_beats, b0);
    check("rst_flush_m_tvalid", m_tvalid, 0);

    // Disabled channel drops, then five packets forwarded
    do_reset();
    p0 = n_pkts;
    ch_enable[2] = 1'b0;
    push_pkt(2, 1, 32'hD0D0_0002, 0);
    n = 0;
    while (!s_tvalid[2] && n < 10) begin
      @(posedge clk); #2;
      n++;
    end
    check("drop_vld_seen", s_tvalid[2], 1);
    repeat (7) @(posedge clk);
    #2 ch_enable[2] = 1'b1;
    push_pkt(0, 2, 32'h0, 1);
    push_pkt(1, 1, 32'h0, 1);
    push_pkt(3, 3, 32'h0, 1);
    push_pkt(0, 1, 32'h0, 1);
    wait_drain("stats_drain", 200);
    check("stats_model_pkts", n_pkts - p0, 5);
`ifdef STREAM_MUX_STATS_EN
    check("pkt_count", pkt_count, 5);
    check("drop_count", drop_count, 7);
`else
    check("pkt_count_tied", pkt_count, 0);
    check("drop_count_tied", drop_count, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
